// File: rtl/aes_mix_columns_seq.sv
// aes_mix_columns_seq
// Sequential AES MixColumns / InvMixColumns engine for the AES-CTR round
// datapath. A 128-bit state is accepted on a valid/ready handshake, mixed
// COLS_PER_CYCLE columns per clock in a working register, and presented on a
// second valid/ready handshake.
// Optional feature macro: AES_MIX_INV_EN. When defined, in_inv is captured at
// accept and selects the inverse coefficient set. When undefined, the mode is
// tied to forward and in_inv is ignored.
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int NCOLS          = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int         N_STEPS  = NCOLS / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(N_STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0][31:0] work_q, work_d;   // element 3 holds column 0
  logic             out_valid_q, out_valid_d;
  logic             in_ready_s;
  logic             accept_s;
  logic             mode_s;

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) byte multiplier cell for 4-bit coefficients (01,02,03,09,0b,0d,0e).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2;
    logic [7:0] a4;
    logic [7:0] a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    gf_mul = (k[0] ? a  : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
             (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  // One column mixer: 16 byte products on a circulant coefficient row.
  function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
    logic [7:0] b0, b1, b2, b3;
    logic [3:0] k0, k1, k2, k3;
    logic [7:0] r0, r1, r2, r3;
    b0 = col[31:24];
    b1 = col[23:16];
    b2 = col[15:8];
    b3 = col[7:0];
    if (inv) begin
      k0 = 4'he; k1 = 4'hb; k2 = 4'hd; k3 = 4'h9;
    end else begin
      k0 = 4'h2; k1 = 4'h3; k2 = 4'h1; k3 = 4'h1;
    end
    r0 = gf_mul(b0, k0) ^ gf_mul(b1, k1) ^ gf_mul(b2, k2) ^ gf_mul(b3, k3);
    r1 = gf_mul(b0, k3) ^ gf_mul(b1, k0) ^ gf_mul(b2, k1) ^ gf_mul(b3, k2);
    r2 = gf_mul(b0, k2) ^ gf_mul(b1, k3) ^ gf_mul(b2, k0) ^ gf_mul(b3, k1);
    r3 = gf_mul(b0, k1) ^ gf_mul(b1, k2) ^ gf_mul(b2, k3) ^ gf_mul(b3, k0);
    mix_column = {r0, r1, r2, r3};
  endfunction

  // in_ready depends on out_ready in DONE so a new state can enter on the
  // same edge that the finished one leaves.
  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s   = in_valid && in_ready_s;

`ifdef AES_MIX_INV_EN
  logic inv_q, inv_d;

  // Mode selection: in_inv is captured only on an accepted state.
  always_comb begin
    inv_d = inv_q;
    if (accept_s) begin
      inv_d = in_inv;
    end else begin
      inv_d = inv_q;
    end
  end

  // Mode flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  assign mode_s = inv_q;
`else
  logic unused_in_inv_s;
  assign unused_in_inv_s = in_inv;
  assign mode_s          = 1'b0;
`endif

  // Next-state logic: accept, per-cycle column mixing, output handshake.
  always_comb begin
    logic [1:0] cidx;
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    cidx        = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_BUSY;
          cnt_d   = 2'd0;
          work_d  = in_state;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          cidx = 2'(int'(cnt_q) * COLS_PER_CYCLE + i);
          work_d[2'd3 - cidx] = mix_column(work_q[2'd3 - cidx], mode_s);
        end
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          cnt_d       = 2'd0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        if (accept_s) begin
          state_d     = ST_BUSY;
          cnt_d       = 2'd0;
          work_d      = in_state;
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 2'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, counter, working register and output-valid flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      work_q      <= 128'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// tb_aes_mix_columns_seq
// Scoreboard bench: three DUT instances (COLS_PER_CYCLE = 1, 2, 4). Stimulus
// pushes expected results; a negedge monitor pops and compares on every
// output handshake and checks accept-to-valid latency and output hold.
// Honours AES_MIX_INV_EN for the expected inverse-mode results.
module tb_aes_mix_columns_seq;

`ifdef AES_MIX_INV_EN
  localparam logic INV_EN = 1'b1;
`else
  localparam logic INV_EN = 1'b0;
`endif
  localparam int NI    = 3;
  localparam int DEPTH = 32;

  logic         clk;
  logic         rst_n     [NI];
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic         in_inv    [NI];
  logic [127:0] in_state  [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_state [NI];

  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  logic [127:0] exp_mem [NI][DEPTH];
  int           exp_wr  [NI];
  int           exp_rd  [NI];
  int           acc_mem [NI][DEPTH];
  int           acc_wr  [NI];
  int           acc_rd  [NI];
  logic         prev_valid [NI];
  logic         prev_ready [NI];
  logic [127:0] prev_state [NI];

  genvar g;
  for (g = 0; g < NI; g++) begin : g_dut
    aes_mix_columns_seq #(
      .COLS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
      .NCOLS(4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_inv   (in_inv[g]),
      .in_state (in_state[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_state(out_state[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int steps(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
  endfunction

  // Reference GF(2^8) multiply: shift-and-add over all 8 bits of b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference matrix product using the full 4x4 coefficient matrix.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [127:0] m;
    logic [127:0] r;
    logic [127:0] t;
    logic [7:0]   acc;
    logic [7:0]   mc;
    logic [7:0]   sb;
    m = inv ? 128'h0e0b0d09_090e0b0d_0d090e0b_0b0d090e
            : 128'h02030101_01020301_01010203_03010102;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          t = m >> (120 - 8 * (4 * row + j));  mc = t[7:0];
          t = s >> (120 - 8 * (4 * c + j));    sb = t[7:0];
          acc = acc ^ gmul(mc, sb);
        end
        r = (r << 8) | {120'h0, acc};
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic push_exp(input int k, input logic [127:0] e);
    exp_mem[k][exp_wr[k] % DEPTH] = e;
    exp_wr[k]++;
  endtask

  // Present one state, wait (bounded) for the accept edge, then scramble inputs.
  task automatic send(input int k, input logic [127:0] st, input logic inv,
                      input logic [127:0] e, output int acc_edge);
    logic ok;
    push_exp(k, e);
    in_state[k] = st;
    in_inv[k]   = inv;
    in_valid[k] = 1'b1;
    ok = 1'b0;
    acc_edge = -1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready[k];
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b0;
    in_inv[k]   = ~inv;
    in_state[k] = ~st;
    if (ok) acc_edge = cyc;
    else fail("accept_timeout");
  endtask

  task automatic drain(input int k);
    int t;
    t = 0;
    while ((exp_rd[k] != exp_wr[k] || out_valid[k]) && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 60) fail("drain_timeout");
  endtask

  // Monitor: latency on valid rise, hold under backpressure, data on handshake.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n[k]) begin
        acc_rd[k]     = acc_wr[k];
        prev_valid[k] = 1'b0;
        prev_ready[k] = 1'b0;
        prev_state[k] = 128'h0;
      end else begin
        if (prev_valid[k] && !prev_ready[k]) begin
          check("hold_valid", 128'(out_valid[k]), 128'h1);
          check("hold_state", out_state[k], prev_state[k]);
        end
        if (out_valid[k] && !prev_valid[k]) begin
          if (acc_rd[k] == acc_wr[k]) begin
            fail("spurious_valid");
          end else begin
            check("latency", 128'(cyc - acc_mem[k][acc_rd[k] % DEPTH]), 128'(steps(k)));
            acc_rd[k]++;
          end
        end
        if (out_valid[k] && out_ready[k]) begin
          if (exp_rd[k] == exp_wr[k]) begin
            fail("unexpected_output");
          end else begin
            check("out_state", out_state[k], exp_mem[k][exp_rd[k] % DEPTH]);
            exp_rd[k]++;
          end
        end
        if (in_valid[k] && in_ready[k]) begin
          acc_mem[k][acc_wr[k] % DEPTH] = cyc + 1;
          acc_wr[k]++;
        end
        prev_valid[k] = out_valid[k];
        prev_ready[k] = out_ready[k];
        prev_state[k] = out_state[k];
      end
    end
  end

  initial begin
    #200000;
    fail("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [127:0] st;
    logic [127:0] save;
    logic         inv;
    int           a;
    int           first_edge;
    int           last_edge;
    int           t;

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; in_valid[k] = 1'b0; in_inv[k] = 1'b0;
      in_state[k] = 128'h0; out_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready", 128'(in_ready[k]), 128'h1);
      check("rst_out_valid", 128'(out_valid[k]), 128'h0);
      check("rst_out_state", out_state[k], 128'h0);
    end
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(posedge clk);
    #1;

    // Forward, CPC=1 (latency 4 checked by the monitor).
    send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, a);
    drain(0);

    // Inverse request, CPC=4.
    st = INV_EN ? 128'hdb135345_f20a225c_01010101_c6c6c6c6
                : ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
    send(2, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, st, a);
    drain(2);

    // Forward CPC=4 and inverse request CPC=2 on the second vector pair.
    send(2, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
         128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, a);
    drain(2);
    st = INV_EN ? 128'hd4d4d4d5_2d26314c_00000000_ffffffff
                : ref_mix(128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b0);
    send(1, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b1, st, a);
    drain(1);

    // Backpressure on CPC=1, then simultaneous handshake + new accept.
    out_ready[0] = 1'b0;
    send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, a);
    t = 0;
    while (!out_valid[0] && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20) fail("bp_valid_timeout");
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready[0]), 128'h0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    send(0, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0,
         128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, a);
    drain(0);

    // Streaming, CPC=2: back-to-back states, one accept every N+1 edges.
    first_edge = 0;
    last_edge  = 0;
    for (int i = 0; i < 8; i++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      send(1, st, inv, ref_mix(st, inv & INV_EN), a);
      if (i == 0) first_edge = a;
      last_edge = a;
    end
    check("stream_period", 128'(last_edge - first_edge), 128'(7 * 3));
    drain(1);

    // Reset in the second BUSY cycle of CPC=1; partial result must vanish.
    st = 128'h00112233_44556677_8899aabb_ccddeeff;
    send(0, st, 1'b1, ref_mix(st, INV_EN), a);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    exp_wr[0] = exp_wr[0] - 1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'h0);
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'h1);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", 128'(out_valid[0]), 128'h0);
    check("post_rst_in_ready", 128'(in_ready[0]), 128'h1);
    check("post_rst_out_state", out_state[0], 128'h0);
    st = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    send(0, st, 1'b0, ref_mix(st, 1'b0), a);
    drain(0);

    // Idle noise on CPC=4: nothing may change without in_valid.
    save = out_state[2];
    for (int i = 0; i < 6; i++) begin
      in_state[2] = {$urandom, $urandom, $urandom, $urandom};
      in_inv[2]   = ~in_inv[2];
      @(negedge clk);
      check("idle_out_valid", 128'(out_valid[2]), 128'h0);
      check("idle_out_state", out_state[2], save);
      @(posedge clk);
      #1;
    end
    st = 128'hc6c6c6c6_01010101_f20a225c_db135345;
    send(2, st, 1'b0, 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc, a);
    drain(2);

    for (int k = 0; k < NI; k++) begin
      check("all_consumed", 128'(exp_rd[k]), 128'(exp_wr[k]));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
